// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the output-layer MAC.
package nn_pkg;
    localparam int N_CLASSES = 10;
    localparam int N_HIDDEN  = 64;
    localparam int ACT_W     = 8;
    localparam int W_W       = 8;
    localparam int SCORE_W   = 26;
    localparam int PROD_W    = 16;  // u8 * s8 always fits in 16-bit signed
    localparam int ACC_W     = 26;  // 64 * |32640| fits with margin
    localparam int CNT_W     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/mac_lane.sv
// One class lane: signed multiply-accumulate with clear, and a clamped score register.
module mac_lane #(
    parameter int SCORE_W = nn_pkg::SCORE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,     // accepted beat
    input  logic                     clr,    // drop the running sum
    input  logic                     load,   // final beat of a well-formed frame
    input  logic [nn_pkg::ACT_W-1:0] act,
    input  logic [nn_pkg::W_W-1:0]   w,
    output logic [SCORE_W-1:0]       score
);
    import nn_pkg::*;

    logic signed [PROD_W-1:0] act_s;
    logic signed [PROD_W-1:0] w_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic        [ACC_W-1:0]  acc_pos;

    // activation is unsigned, weight is two's complement
    assign act_s    = {{(PROD_W-ACT_W){1'b0}}, act};
    assign w_s      = {{(PROD_W-W_W){w[W_W-1]}}, w};
    assign prod     = act_s * w_s;
    assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // negative sums report as zero score
    assign acc_pos  = acc_next[ACC_W-1] ? '0 : acc_next;

    // accumulate beats; score captures the sum including the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            score <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (en)
                acc <= acc_next;
            if (load)
                score <= SCORE_W'(acc_pos);
        end
    end
endmodule

// File: rtl/output_layer_mac.sv
// Output layer: ten parallel MAC lanes framed by a beat counter and IDLE/ACCUM/DONE FSM.
module output_layer_mac #(
    parameter int N_HIDDEN = nn_pkg::N_HIDDEN,
    parameter int SCORE_W  = nn_pkg::SCORE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [nn_pkg::ACT_W-1:0] act,
    input  logic [nn_pkg::W_W-1:0]   w0,
    input  logic [nn_pkg::W_W-1:0]   w1,
    input  logic [nn_pkg::W_W-1:0]   w2,
    input  logic [nn_pkg::W_W-1:0]   w3,
    input  logic [nn_pkg::W_W-1:0]   w4,
    input  logic [nn_pkg::W_W-1:0]   w5,
    input  logic [nn_pkg::W_W-1:0]   w6,
    input  logic [nn_pkg::W_W-1:0]   w7,
    input  logic [nn_pkg::W_W-1:0]   w8,
    input  logic [nn_pkg::W_W-1:0]   w9,
    input  logic                     in_last,
    output logic [SCORE_W-1:0]       s0,
    output logic [SCORE_W-1:0]       s1,
    output logic [SCORE_W-1:0]       s2,
    output logic [SCORE_W-1:0]       s3,
    output logic [SCORE_W-1:0]       s4,
    output logic [SCORE_W-1:0]       s5,
    output logic [SCORE_W-1:0]       s6,
    output logic [SCORE_W-1:0]       s7,
    output logic [SCORE_W-1:0]       s8,
    output logic [SCORE_W-1:0]       s9,
    output logic                     Output_Valid,
    output logic                     frame_err
);
    import nn_pkg::*;

    state_t                              state, state_nxt;
    logic [CNT_W-1:0]                    cnt;
    logic                                accept;
    logic                                cnt_full;
    logic                                last_ok;
    logic                                bad;
    logic                                err_q;
    logic                                lane_clr;
    logic [N_CLASSES-1:0][W_W-1:0]       w_vec;
    logic [N_CLASSES-1:0][SCORE_W-1:0]   s_vec;

    assign w_vec = {w9, w8, w7, w6, w5, w4, w3, w2, w1, w0};
    assign {s9, s8, s7, s6, s5, s4, s3, s2, s1, s0} = s_vec;

    assign accept   = in_valid && in_ready;
    assign cnt_full = (cnt == CNT_W'(N_HIDDEN-1));
    assign last_ok  = accept && in_last && cnt_full;
    // in_last off the final index, or the final index without in_last
    assign bad      = accept && (in_last != cnt_full);
    assign lane_clr = (state == DONE) || bad;
    assign frame_err = err_q;

    // next state and handshake outputs
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        Output_Valid = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = !rst;
                if (last_ok)
                    state_nxt = DONE;
                else if (bad)
                    state_nxt = IDLE;
                else if (accept)
                    state_nxt = ACCUM;
            end
            DONE: begin
                Output_Valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register, beat counter and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= bad;
            if (last_ok || bad)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CLASSES; k++) begin : g_lane
        mac_lane #(.SCORE_W(SCORE_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (accept),
            .clr   (lane_clr),
            .load  (last_ok),
            .act   (act),
            .w     (w_vec[k]),
            .score (s_vec[k])
        );
    end
endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac with a frame-level reference model.
module tb_output_layer_mac;
    localparam int NH = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        act;
    logic signed [7:0] wv [10];
    logic              in_last;
    logic [25:0]       s [10];
    logic              Output_Valid;
    logic              frame_err;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int cyc = 0;
    int ov_prev = -1, ov_last = -1;
    int nrdy0 = 0;

    // reference model state
    longint m_acc [10];
    longint m_s [10];
    int     m_cnt;
    bit     m_done, m_err, m_ov;

    output_layer_mac dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .act(act),
        .w0(wv[0]), .w1(wv[1]), .w2(wv[2]), .w3(wv[3]), .w4(wv[4]),
        .w5(wv[5]), .w6(wv[6]), .w7(wv[7]), .w8(wv[8]), .w9(wv[9]),
        .in_last(in_last),
        .s0(s[0]), .s1(s[1]), .s2(s[2]), .s3(s[3]), .s4(s[4]),
        .s5(s[5]), .s6(s[6]), .s7(s[7]), .s8(s[8]), .s9(s[9]),
        .Output_Valid(Output_Valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // frame model: sum act*w per class, judge frame shape by beat index
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int k = 0; k < 10; k++) begin m_acc[k] = 0; m_s[k] = 0; end
            m_cnt = 0; m_done = 0; m_err = 0; m_ov = 0;
        end else begin
            m_err = 0; m_ov = 0;
            if (m_done) begin
                m_done = 0;
            end else if (in_valid) begin
                for (int k = 0; k < 10; k++)
                    m_acc[k] += longint'(act) * longint'(wv[k]);
                m_cnt++;
                if (in_last && m_cnt == NH) begin
                    for (int k = 0; k < 10; k++) m_s[k] = (m_acc[k] > 0) ? m_acc[k] : 0;
                    m_ov = 1; m_done = 1;
                end else if (in_last || m_cnt == NH) begin
                    m_err = 1;
                end
                if (in_last || m_cnt == NH) begin
                    for (int k = 0; k < 10; k++) m_acc[k] = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(!rst && !m_done));
            chk("Output_Valid", 64'(Output_Valid), 64'(m_ov));
            chk("frame_err", 64'(frame_err), 64'(m_err));
            for (int k = 0; k < 10; k++) chk($sformatf("s%0d", k), 64'(s[k]), 64'(m_s[k]));
            if (Output_Valid === 1'b1) begin ov_prev = ov_last; ov_last = cyc; end
            if (in_ready === 1'b0 && !rst) nrdy0++;
        end
    end

    function automatic logic [7:0] act_of(input int mode, input int i);
        case (mode)
            0: return 8'd1;
            1: return 8'd255;
            2: return 8'd2;
            3: return 8'(i % 8);
            default: return 8'd3;
        endcase
    endfunction

    function automatic logic signed [7:0] w_of(input int mode, input int i, input int k);
        case (mode)
            0: return 8'(k);
            1: return (k == 0) ? -8'sd128 : (k == 1) ? 8'sd127 : 8'sd0;
            2: return 8'(k - 5);
            3: return 8'(((i + 3 * k) % 11) - 5);
            default: return 8'(k);
        endcase
    endfunction

    // nbeats beats; in_last on index last_at (-1: never); leaves in_valid high
    task automatic send_frame(input int nbeats, input int last_at, input int mode);
        for (int i = 0; i < nbeats; i++) begin
            bit r;
            int tries;
            in_valid = 1'b1;
            act = act_of(mode, i);
            for (int k = 0; k < 10; k++) wv[k] = w_of(mode, i, k);
            in_last = (i == last_at);
            tries = 0;
            do begin
                @(negedge clk); r = in_ready;
                @(posedge clk); #1;
                tries++;
            end while (!r && tries < 8);
            if (!r) begin
                n_chk++; n_fail++;
                $display("FAIL beat_accept_timeout: beat %0d not accepted, in_ready=%0b expected 1", i, r);
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; act = '0;
        for (int k = 0; k < 10; k++) wv[k] = '0;
        @(posedge clk); #1;
        chk_en = 1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_s9", 64'(s[9]), 64'd0);
        idle(1);
        rst = 1'b0;
        idle(1);

        // act=1, wk=k: sk = 64k
        send_frame(NH, NH-1, 0);
        chk("t1_ov", 64'(Output_Valid), 64'd1);
        chk("t1_ready_done", 64'(in_ready), 64'd0);
        chk("t1_s9", 64'(s[9]), 64'd576);
        chk("t1_s4", 64'(s[4]), 64'd256);
        idle(1);
        chk("t1_ov_pulse", 64'(Output_Valid), 64'd0);
        chk("t1_ready_back", 64'(in_ready), 64'd1);
        idle(2);

        // extremes: clamp negative, max positive
        send_frame(NH, NH-1, 1);
        chk("t2_s0", 64'(s[0]), 64'd0);
        chk("t2_s1", 64'(s[1]), 64'd2072640);
        idle(2);

        // early in_last at beat 10
        send_frame(11, 10, 0);
        chk("t3_err", 64'(frame_err), 64'd1);
        chk("t3_ov", 64'(Output_Valid), 64'd0);
        chk("t3_s1_kept", 64'(s[1]), 64'd2072640);
        idle(1);
        chk("t3_err_pulse", 64'(frame_err), 64'd0);

        // single-beat frame
        send_frame(1, 0, 0);
        chk("t3b_err", 64'(frame_err), 64'd1);
        idle(2);

        // 64 beats with no in_last
        send_frame(NH, -1, 0);
        chk("t4_err", 64'(frame_err), 64'd1);
        chk("t4_idle_ready", 64'(in_ready), 64'd1);
        chk("t4_s1_kept", 64'(s[1]), 64'd2072640);
        idle(2);

        // reset mid-frame, then a clean frame
        send_frame(30, -1, 0);
        rst = 1'b1;
        idle(2);
        chk("t5_rst_ready", 64'(in_ready), 64'd0);
        chk("t5_rst_s1", 64'(s[1]), 64'd0);
        rst = 1'b0;
        #1;
        chk("t5_ready_after_rst", 64'(in_ready), 64'd1);
        send_frame(NH, NH-1, 2);
        chk("t5_s9", 64'(s[9]), 64'd512);
        chk("t5_s6", 64'(s[6]), 64'd128);
        chk("t5_s0", 64'(s[0]), 64'd0);
        idle(2);

        // two frames with in_valid held high throughout
        nrdy0 = 0;
        send_frame(NH, NH-1, 3);
        send_frame(NH, NH-1, 4);
        idle(3);
        chk("t6_ov_gap", 64'(ov_last - ov_prev), 64'd65);
        chk("t6_notready_cycles", 64'(nrdy0), 64'd2);
        chk("t6_s9", 64'(s[9]), 64'd1728);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
